// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen
// Description : Raster-order pixel feeder for a 3x3 convolution stage. Keeps
//               two previous image lines, presents a sliding 3x3 window and
//               emits the stage strobes en_1..en_5 plus a frame_done pulse.
//               Only "valid" windows (no padding) raise en_1.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [7:0] pix_in,
  output logic [7:0] pix_00,
  output logic [7:0] pix_01,
  output logic [7:0] pix_02,
  output logic [7:0] pix_10,
  output logic [7:0] pix_11,
  output logic [7:0] pix_12,
  output logic [7:0] pix_20,
  output logic [7:0] pix_21,
  output logic [7:0] pix_22,
  output logic       en_1,
  output logic       en_2,
  output logic       en_3,
  output logic       en_4,
  output logic       en_5,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] C_COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] C_ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);

  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] w_col;
  logic [CNT_W-1:0] w_row;
  logic [CNT_W-1:0] w_col_nxt;
  logic [CNT_W-1:0] w_row_nxt;
  logic             w_en1_nxt;
  logic             w_done_nxt;

  logic [7:0] r_lb0 [IMG_W];
  logic [7:0] r_lb1 [IMG_W];
  logic [7:0] r_win [3][3];
  logic [5:1] r_en;
  logic       r_frame_done;

  // Position of the current pixel (frame_start makes it (0,0)) and the counter advance.
  always_comb begin
    w_col      = frame_start ? '0 : r_col;
    w_row      = frame_start ? '0 : r_row;
    w_col_nxt  = w_col;
    w_row_nxt  = w_row;
    w_en1_nxt  = 1'b0;
    w_done_nxt = 1'b0;
    if (pix_valid) begin
      if (w_col == C_COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = (w_row == C_ROW_LAST) ? '0 : w_row + CNT_W'(1);
      end else begin
        w_col_nxt = w_col + CNT_W'(1);
      end
      w_en1_nxt  = (w_row >= C_TWO) && (w_col >= C_TWO);
      w_done_nxt = (w_row == C_ROW_LAST) && (w_col == C_COL_LAST);
    end
  end

  // Column/row counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  // Line buffers: no reset, each entry is written before the window can expose it.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_lb1[w_col] <= r_lb0[w_col];
      r_lb0[w_col] <= pix_in;
    end
  end

  // Sliding window: shift left, new right column from the pre-write line buffer values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= 8'd0;
        end
      end
    end else if (pix_valid) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= r_lb1[w_col];
      r_win[1][2] <= r_lb0[w_col];
      r_win[2][2] <= pix_in;
    end
  end

  // Stage strobe chain and end-of-frame pulse; the chain shifts regardless of pix_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_en         <= {r_en[4:1], w_en1_nxt};
      r_frame_done <= w_done_nxt;
    end
  end

  assign pix_00     = r_win[0][0];
  assign pix_01     = r_win[0][1];
  assign pix_02     = r_win[0][2];
  assign pix_10     = r_win[1][0];
  assign pix_11     = r_win[1][1];
  assign pix_12     = r_win[1][2];
  assign pix_20     = r_win[2][0];
  assign pix_21     = r_win[2][1];
  assign pix_22     = r_win[2][2];
  assign en_1       = r_en[1];
  assign en_2       = r_en[2];
  assign en_3       = r_en[3];
  assign en_4       = r_en[4];
  assign en_5       = r_en[5];
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
